// File: rtl/arb_mux.sv
// Registered N:1 valid/ready multiplexer with built-in fixed-priority or round-robin arbitration.
// One beat per cycle moves from the winning input into a single output register.
module arb_mux #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned DBL_W = 2 * NUM_IN;

    logic [SEL_W-1:0]  last;
    logic [SEL_W-1:0]  grant;
    logic              found;
    logic              can_load;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;
    logic [DBL_W-1:0]  dbl;
    logic [NUM_IN-1:0] rot;
    int unsigned       start;
    int unsigned       pos;

    // Rotate the request vector so the highest-priority index lands at bit 0,
    // then take the lowest set bit; fixed priority is simply a rotation of 0.
    always_comb begin
        start = 0;
        pos   = 0;
        found = 1'b0;
        if (mode) begin
            start = (int'(last) + 1) % NUM_IN;
        end
        dbl = {in_valid, in_valid} >> start;
        rot = dbl[NUM_IN-1:0];
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos   = i;
                found = 1'b1;
            end
        end
        grant = SEL_W'((start + pos) % NUM_IN);
    end

    assign can_load = !out_valid || out_ready;
    assign xfer     = found && can_load && !rst;

    // Accept strobe and data selection for the granted input.
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant;
            if (mode) begin
                last <= grant;
            end
        end else if (out_ready) begin
            // Consumed with nothing new to load: data and index stay stale.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: hand-derived vector table, directed corner sequences,
// and a randomized run compared against a priority-list reference model.
module tb_arb_mux;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    mode;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct {
        logic        rst;
        logic        mode;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = base + 32'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; out_ready = 1'b0; mode = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Reference model: the winner is the first valid entry in a priority list.
    logic        m_valid;
    logic [31:0] m_data;
    logic [1:0]  m_sel;
    int          m_last;

    function automatic int pick(input logic md, input logic [3:0] v, input int lst);
        int order[$];
        for (int k = 0; k < NUM_IN; k++) order.push_back(md ? (lst + 1 + k) % NUM_IN : k);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    initial begin
        logic [3:0] exp_r;
        int g;

        rst = 1'b1; mode = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
        #1;
        do_reset();

        // Idle after reset
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_sel", 32'(out_sel), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_ready", 32'(in_ready), 0);
            tick();
            chk("idle_ov", 32'(out_valid), 0);
        end

        // Vector table: consecutive cycles from reset, data of input i = A000000i
        //                rst  mode valid    ordy rdy      ov   sel    data
        vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA0000001};
        vecs[2]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA0000001};
        vecs[3]  = '{1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA0000001};
        vecs[4]  = '{1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA0000003};
        vecs[5]  = '{1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0000000};
        vecs[6]  = '{1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA0000001};
        vecs[7]  = '{1'b0, 1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA0000002};
        vecs[8]  = '{1'b0, 1'b0, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA0000001};
        vecs[9]  = '{1'b0, 1'b1, 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA0000003};
        vecs[10] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA0000003};
        vecs[11] = '{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'hA0000003};
        vecs[12] = '{1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0000000};

        do_reset();
        set_data(32'hA0000000);
        foreach (vecs[v]) begin
            rst = vecs[v].rst; mode = vecs[v].mode;
            in_valid = vecs[v].valid; out_ready = vecs[v].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", v), 32'(in_ready), 32'(vecs[v].exp_ready));
            tick();
            chk($sformatf("vec%0d_ov", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            chk($sformatf("vec%0d_sel", v), 32'(out_sel), 32'(vecs[v].exp_sel));
            chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
        end
        rst = 1'b0;

        // Round-robin rotation with all inputs valid
        do_reset();
        set_data(32'hB0000000);
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_sel", 32'(out_sel), 32'(k % 4));
            chk("rr_data", out_data, 32'hB0000000 + 32'(k % 4));
        end

        // Backpressure: beat from input 2 held for three stalled cycles
        do_reset();
        set_data(32'hC0000000);
        in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        mode = 1'b0; in_valid = 4'b0100; out_ready = 1'b1;
        tick();
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 0);
            tick();
            chk("bp_ov", 32'(out_valid), 1);
            chk("bp_sel", 32'(out_sel), 2);
            chk("bp_data", out_data, 32'hDEADBEEF);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("rel_sel", 32'(out_sel), 0);
        chk("rel_data", out_data, 32'hC0000000);

        // Consume and load in the same cycle keeps out_valid high
        in_valid = 4'b1000;
        @(negedge clk);
        chk("cl_ready", 32'(in_ready), 32'b1000);
        tick();
        chk("cl_ov", 32'(out_valid), 1);
        chk("cl_sel", 32'(out_sel), 3);
        chk("cl_data", out_data, 32'hC0000003);

        // Mid-stream reset drops the beat and restores the round-robin pointer
        mode = 1'b1; in_valid = 4'b0100;
        tick();
        chk("pre_rst_sel", 32'(out_sel), 2);
        rst = 1'b1; in_valid = 4'b0001;
        @(negedge clk);
        chk("rst_cyc_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        chk("rst_cyc_ov", 32'(out_valid), 0);
        in_valid = 4'b1111;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("post_rst_sel", 32'(out_sel), 0);

        // Randomized run against the reference model
        do_reset();
        m_valid = 1'b0; m_data = '0; m_sel = '0; m_last = NUM_IN - 1;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(63) == 0);
            if ($urandom_range(15) == 0) mode = ~mode;
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
            @(negedge clk);
            g = pick(mode, in_valid, m_last);
            exp_r = (!rst && (!m_valid || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("rnd_ready", 32'(in_ready), 32'(exp_r));
            chk("rnd_ov", 32'(out_valid), 32'(m_valid));
            chk("rnd_sel", 32'(out_sel), 32'(m_sel));
            chk("rnd_data", out_data, m_data);
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b0; m_data = '0; m_sel = '0; m_last = NUM_IN - 1;
            end else if (exp_r != 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*WIDTH +: WIDTH];
                m_sel   = 2'(g);
                if (mode) m_last = g;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
